// File: rtl/uart_rx_pkg.sv
// Shared UART configuration: default line parameters, the clocks-per-bit
// helper and the receiver FSM state encoding.
package uart_rx_pkg;

    localparam int unsigned CLK_FREQ_HZ_DEF = 100_000_000;
    localparam int unsigned BAUD_RATE_DEF   = 1_000_000;

    // Number of core clocks per serial bit; the ratio is expected to be exact.
    function automatic int unsigned clksPerBit(input int unsigned clkHz,
                                               input int unsigned baud);
        return clkHz / baud;
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_IDLE = 3'd4
    } rxState_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Small synchronous first-word-fall-through FIFO for received bytes.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module uart_rx_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] pushData_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] headData_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wrPtr_q;
    logic [AW:0]      rdPtr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             doPush;
    logic             doPop;

    assign empty_o    = (wrPtr_q == rdPtr_q);
    assign full_o     = (wrPtr_q[AW] != rdPtr_q[AW]) &&
                        (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
    assign doPop      = pop_i && !empty_o;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign doPush     = push_i && (!full_o || doPop);
    assign headData_o = mem_q[rdPtr_q[AW-1:0]];

    // Pointer update; wrap-around comes from the natural overflow of the counters.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
            if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
        end
    end

    // Storage write; contents are qualified by the pointers so no reset is needed.
    always_ff @(posedge clk_i) begin
        if (doPush) mem_q[wrPtr_q[AW-1:0]] <= pushData_i;
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1, LSB first, idle-high line. Bytes are rebuilt by a
// bit-timing FSM and queued in a FWFT FIFO; framing and overrun errors are sticky.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = CLK_FREQ_HZ_DEF,
    parameter int unsigned BAUD_RATE   = BAUD_RATE_DEF,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       rxd_i,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    input  logic       rx_ready_i,
    output logic       busy_o,
    output logic       frame_err_o,
    output logic       overrun_o,
    input  logic       err_clr_i
);

    localparam int unsigned CLKS_PER_BIT = clksPerBit(CLK_FREQ_HZ, BAUD_RATE);
    localparam int unsigned CW           = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_HALF   = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_FULL   = CW'(CLKS_PER_BIT - 1);

    logic [1:0]    sync_q;
    logic          rxs;
    rxState_e      state_q;
    logic [CW-1:0] bitCnt_q;
    logic [2:0]    bitIdx_q;
    logic [7:0]    shift_q;
    logic          frameErr_q;
    logic          overrun_q;

    logic          pushByte_d;
    logic          frameErrSet_d;
    logic          overrunSet_d;
    logic          fifoPop_d;
    logic          fifoFull;
    logic          fifoEmpty;
    logic [7:0]    fifoHead;

    assign rxs = sync_q[1];

    // Two-flop synchroniser; preset high so reset never looks like a start bit.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) sync_q <= 2'b11;
        else         sync_q <= {sync_q[0], rxd_i};
    end

    // Stop-bit sample points decide push or framing error in the same cycle.
    assign pushByte_d    = (state_q == ST_STOP) && (bitCnt_q == CNT_FULL) && rxs;
    assign frameErrSet_d = (state_q == ST_STOP) && (bitCnt_q == CNT_FULL) && !rxs;
    assign fifoPop_d     = rx_ready_i && !fifoEmpty;
    assign overrunSet_d  = pushByte_d && fifoFull && !fifoPop_d;

    // Receiver FSM: start-bit qualification at mid-bit, then one sample per bit period.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            bitCnt_q <= '0;
            bitIdx_q <= '0;
            shift_q  <= 8'hFF;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!rxs) begin
                        state_q  <= ST_START;
                        bitCnt_q <= '0;
                    end
                end
                ST_START: begin
                    if (bitCnt_q == CNT_HALF) begin
                        bitCnt_q <= '0;
                        bitIdx_q <= '0;
                        state_q  <= rxs ? ST_IDLE : ST_DATA;
                    end else begin
                        bitCnt_q <= bitCnt_q + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (bitCnt_q == CNT_FULL) begin
                        bitCnt_q <= '0;
                        shift_q  <= {rxs, shift_q[7:1]};
                        if (bitIdx_q == 3'd7) state_q  <= ST_STOP;
                        else                  bitIdx_q <= bitIdx_q + 1'b1;
                    end else begin
                        bitCnt_q <= bitCnt_q + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (bitCnt_q == CNT_FULL) begin
                        bitCnt_q <= '0;
                        state_q  <= rxs ? ST_IDLE : ST_WAIT_IDLE;
                    end else begin
                        bitCnt_q <= bitCnt_q + 1'b1;
                    end
                end
                ST_WAIT_IDLE: begin
                    if (rxs) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Sticky error flags; a new error wins over a clear arriving in the same cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            frameErr_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            if (frameErrSet_d)  frameErr_q <= 1'b1;
            else if (err_clr_i) frameErr_q <= 1'b0;
            if (overrunSet_d)   overrun_q  <= 1'b1;
            else if (err_clr_i) overrun_q  <= 1'b0;
        end
    end

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .push_i     (pushByte_d),
        .pushData_i (shift_q),
        .pop_i      (fifoPop_d),
        .headData_o (fifoHead),
        .full_o     (fifoFull),
        .empty_o    (fifoEmpty)
    );

    assign rx_valid_o  = !fifoEmpty;
    assign rx_data_o   = fifoEmpty ? 8'h00 : fifoHead;
    assign busy_o      = (state_q != ST_IDLE);
    assign frame_err_o = frameErr_q;
    assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed plus randomized bench for uart_rx at 100 MHz / 1 Mbaud (100 clocks per bit).
// A UART line driver feeds rxd_i; expected bytes and flags come from a queue-based
// model of "what was sent and what the FIFO should be holding".
module tb_uart_rx;

    localparam int CPB   = 100;
    localparam int DEPTH = 4;

    logic       clk    = 1'b0;
    logic       rstN   = 1'b0;
    logic       rxd    = 1'b1;
    logic       ready  = 1'b0;
    logic       errClr = 1'b0;
    logic [7:0] rxData;
    logic       rxValid;
    logic       busy;
    logic       frameErr;
    logic       overrun;

    int         assertCount = 0;
    int         failCount   = 0;

    logic [7:0] expQ[$];
    logic [7:0] gotQ[$];
    logic       expOverrun;

    uart_rx #(
        .CLK_FREQ_HZ (100_000_000),
        .BAUD_RATE   (1_000_000),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rstN),
        .rxd_i       (rxd),
        .rx_data_o   (rxData),
        .rx_valid_o  (rxValid),
        .rx_ready_i  (ready),
        .busy_o      (busy),
        .frame_err_o (frameErr),
        .overrun_o   (overrun),
        .err_clr_i   (errClr)
    );

    // 100 MHz core clock
    always #5 clk = ~clk;

    // Safety net so a stuck design can never hang the run
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // One comparison: counts it and reports tag/observed/expected on a miss
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Drive one 8N1 frame; the line is left at the stop-bit level afterwards
    task automatic applyStimulus(input logic [7:0] b, input logic stopBit);
        @(negedge clk);
        rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (CPB) @(negedge clk);
        end
        rxd = stopBit;
        repeat (CPB) @(negedge clk);
    endtask

    // Reference FIFO behaviour: store if there is room, otherwise drop and flag overrun
    task automatic modelPush(input logic [7:0] b);
        if (expQ.size() == DEPTH) expOverrun = 1'b1;
        else                      expQ.push_back(b);
    endtask

    // Pop continuously until the FIFO is empty (bounded), comparing against the model
    task automatic drainAndCheck(input string tag, input int expectedCount);
        int n;
        n = 0;
        @(negedge clk);
        ready = 1'b1;
        for (int c = 0; c < 3 * DEPTH; c++) begin
            if (rxValid) begin
                checkOutput(tag, rxData, expQ.size() > 0 ? expQ.pop_front() : 8'hxx);
                n++;
            end
            @(negedge clk);
        end
        ready = 1'b0;
        checkOutput({tag, "_count"}, n, expectedCount);
        checkOutput({tag, "_empty"}, rxValid, 1'b0);
    endtask

    initial begin
        int         lat;
        int         busyCnt;
        int         busyLowCnt;
        logic       busyPrev;
        logic [7:0] b;
        logic [7:0] poppedAtPush;

        expOverrun = 1'b0;

        // ---------------- reset state ----------------
        repeat (5) @(negedge clk);
        checkOutput("rst_valid", rxValid, 1'b0);
        checkOutput("rst_data", rxData, 8'h00);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_ferr", frameErr, 1'b0);
        checkOutput("rst_ovr", overrun, 1'b0);
        rstN = 1'b1;
        repeat (10) @(negedge clk);

        // ---------------- 1: single byte latency ----------------
        $display("[TB] step 1: byte 0x55 latency");
        lat = 0;
        busyPrev = 1'b0;
        fork
            applyStimulus(8'h55, 1'b1);
            begin
                @(negedge rxd);
                while (!rxValid && lat < 2000) begin
                    busyPrev = busy;
                    @(posedge clk);
                    #1;
                    lat++;
                end
            end
        join
        checkOutput("t1_latency_in_window", (lat >= 951 && lat <= 953), 1'b1);
        checkOutput("t1_busy_before", busyPrev, 1'b1);
        checkOutput("t1_valid", rxValid, 1'b1);
        checkOutput("t1_data", rxData, 8'h55);
        checkOutput("t1_busy_after", busy, 1'b0);
        checkOutput("t1_flags", {frameErr, overrun}, 2'b00);
        expQ.push_back(8'h55);
        drainAndCheck("t1_drain", 1);

        // ---------------- 2: glitch rejection ----------------
        $display("[TB] step 2: 30-clock glitch");
        @(negedge clk);
        rxd = 1'b0;
        busyCnt = 0;
        for (int c = 0; c < 200; c++) begin
            if (c == 30) rxd = 1'b1;
            @(negedge clk);
            if (busy) busyCnt++;
        end
        checkOutput("t2_busy_seen", busyCnt > 0, 1'b1);
        checkOutput("t2_busy_short", busyCnt <= 55, 1'b1);
        checkOutput("t2_busy_end", busy, 1'b0);
        checkOutput("t2_valid", rxValid, 1'b0);
        checkOutput("t2_flags", {frameErr, overrun}, 2'b00);

        // ---------------- 3: framing error, held-low line ----------------
        $display("[TB] step 3: framing error and break");
        applyStimulus(8'hA5, 1'b0);
        checkOutput("t3_ferr_set", frameErr, 1'b1);
        busyLowCnt = 0;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            if (!busy) busyLowCnt++;
        end
        checkOutput("t3_busy_held", busyLowCnt, 0);
        rxd = 1'b1;
        repeat (20) @(negedge clk);
        checkOutput("t3_idle_again", busy, 1'b0);
        applyStimulus(8'h3C, 1'b1);
        checkOutput("t3_ferr_sticky", frameErr, 1'b1);
        expQ.push_back(8'h3C);
        drainAndCheck("t3_drain", 1);
        @(negedge clk);
        errClr = 1'b1;
        @(negedge clk);
        errClr = 1'b0;
        checkOutput("t3_ferr_clr", frameErr, 1'b0);

        // ---------------- 4: overrun ----------------
        $display("[TB] step 4: overrun");
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(8'(i), 1'b1);
            modelPush(8'(i));
        end
        checkOutput("t4_overrun", overrun, expOverrun);
        drainAndCheck("t4_drain", 4);
        @(negedge clk);
        errClr = 1'b1;
        @(negedge clk);
        errClr = 1'b0;
        expOverrun = 1'b0;
        checkOutput("t4_ovr_clr", overrun, 1'b0);

        // ---------------- 5a: random back-to-back stream ----------------
        $display("[TB] step 5: random stream");
        gotQ.delete();
        expQ.delete();
        @(negedge clk);
        ready = 1'b1;
        fork
            for (int i = 0; i < 16; i++) begin
                b = 8'($urandom);
                expQ.push_back(b);
                applyStimulus(b, 1'b1);
            end
            begin
                for (int c = 0; c < 16 * 1100 && gotQ.size() < 16; c++) begin
                    @(negedge clk);
                    if (rxValid && ready) gotQ.push_back(rxData);
                end
            end
        join
        ready = 1'b0;
        checkOutput("t5_count", gotQ.size(), 16);
        for (int i = 0; i < 16 && i < gotQ.size(); i++)
            checkOutput($sformatf("t5_byte%0d", i), gotQ[i], expQ[i]);
        checkOutput("t5_flags", {frameErr, overrun}, 2'b00);
        expQ.delete();

        // ---------------- 5b: full FIFO with pop on the push cycle ----------------
        $display("[TB] step 5b: full with coincident pop");
        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom);
            applyStimulus(b, 1'b1);
            modelPush(b);
        end
        b = 8'($urandom);
        poppedAtPush = 8'h00;
        fork
            applyStimulus(b, 1'b1);
            begin
                @(negedge rxd);
                repeat (952) @(posedge clk);
                @(negedge clk);
                poppedAtPush = rxData;
                ready = 1'b1;
                @(negedge clk);
                ready = 1'b0;
            end
        join
        checkOutput("t5b_popped", poppedAtPush, expQ.pop_front());
        modelPush(b);
        checkOutput("t5b_no_overrun", overrun, expOverrun);
        drainAndCheck("t5b_drain", 4);

        // ---------------- 6: asynchronous reset mid-frame ----------------
        $display("[TB] step 6: reset during data bit 3");
        applyStimulus(8'h81, 1'b1);
        checkOutput("t6_pre_valid", rxValid, 1'b1);
        fork
            applyStimulus(8'hE7, 1'b1);
            begin
                @(negedge rxd);
                repeat (3 + 50 + 300 + 50) @(posedge clk);
                #1;
                checkOutput("t6_busy_pre", busy, 1'b1);
                #1;
                rstN = 1'b0;
                #1;
                checkOutput("t6_rst_valid", rxValid, 1'b0);
                checkOutput("t6_rst_data", rxData, 8'h00);
                checkOutput("t6_rst_busy", busy, 1'b0);
                checkOutput("t6_rst_flags", {frameErr, overrun}, 2'b00);
            end
        join
        rxd = 1'b1;
        repeat (5) @(negedge clk);
        rstN = 1'b1;
        repeat (200) @(negedge clk);
        expQ.delete();
        applyStimulus(8'hC3, 1'b1);
        expQ.push_back(8'hC3);
        drainAndCheck("t6_drain", 1);
        checkOutput("t6_flags", {frameErr, overrun}, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
